// File: rtl/bru_issue_queue_pkg.sv
// Shared definitions for the branch-unit issue queue: status layout, tag width, FU_BRU op bits.
// Combinational constants only; no latency, no backpressure.
package bru_issue_queue_pkg;

  localparam int INST_STATE_WD = 65;
  localparam int PC_LSB        = 0;
  localparam int PC_MSB        = 31;
  localparam int IMM_LSB       = 32;
  localparam int IMM_MSB       = 63;
  localparam int WE_BIT        = 64;

  localparam int IQ_TAG_WD     = 6;
  localparam int BRU_OP_WD     = 12;

  localparam int OP_BEQ  = 0;
  localparam int OP_BNE  = 1;
  localparam int OP_BLT  = 2;
  localparam int OP_BGE  = 3;
  localparam int OP_BLTU = 4;
  localparam int OP_BGEU = 5;
  localparam int OP_BEQZ = 6;
  localparam int OP_BNEZ = 7;
  localparam int OP_BLEZ = 8;
  localparam int OP_BGEZ = 9;
  localparam int OP_JAL  = 10;
  localparam int OP_JALR = 11;

endpackage

// File: rtl/bru_iq_entry.sv
// One queue slot: holds a branch micro-op and its two operands while snooping the CDB for pending sources.
// Latency: state updates on the next edge; backpressure: none, the top decides load/shift/hold.
module bru_iq_entry
  import bru_issue_queue_pkg::*;
#(
  parameter int TAG_WD = IQ_TAG_WD,
  parameter int ST_WD  = INST_STATE_WD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   load,
  input  logic                   shift,
  input  logic [BRU_OP_WD-1:0]   disp_op,
  input  logic [ST_WD-1:0]       disp_status,
  input  logic [1:0]             disp_rdy,
  input  logic [1:0][TAG_WD-1:0] disp_tag,
  input  logic [1:0][31:0]       disp_data,
  input  logic                   up_valid,
  input  logic [BRU_OP_WD-1:0]   up_op,
  input  logic [ST_WD-1:0]       up_status,
  input  logic [1:0]             up_rdy,
  input  logic [1:0][TAG_WD-1:0] up_tag,
  input  logic [1:0][31:0]       up_data,
  input  logic                   cdb_valid,
  input  logic [TAG_WD-1:0]      cdb_tag,
  input  logic [31:0]            cdb_data,
  output logic                   valid,
  output logic [BRU_OP_WD-1:0]   op,
  output logic [ST_WD-1:0]       status,
  output logic [1:0]             rdy,
  output logic [1:0][TAG_WD-1:0] tag,
  output logic [1:0][31:0]       data
);

  logic                   n_valid;
  logic [BRU_OP_WD-1:0]   n_op;
  logic [ST_WD-1:0]       n_status;
  logic [1:0]             n_rdy;
  logic [1:0][TAG_WD-1:0] n_tag;
  logic [1:0][31:0]       n_data;

  // Wakeup is applied after the source mux so shifted and freshly dispatched operands also catch the CDB.
  always_comb begin
    n_valid  = valid;
    n_op     = op;
    n_status = status;
    n_rdy    = rdy;
    n_tag    = tag;
    n_data   = data;
    if (load) begin
      n_valid  = 1'b1;
      n_op     = disp_op;
      n_status = disp_status;
      n_rdy    = disp_rdy;
      n_tag    = disp_tag;
      n_data   = disp_data;
    end else if (shift) begin
      n_valid  = up_valid;
      n_op     = up_op;
      n_status = up_status;
      n_rdy    = up_rdy;
      n_tag    = up_tag;
      n_data   = up_data;
    end
    for (int s = 0; s < 2; s++) begin
      if (cdb_valid && !n_rdy[s] && n_tag[s] == cdb_tag) begin
        n_rdy[s]  = 1'b1;
        n_data[s] = cdb_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= 1'b0;
      op     <= '0;
      status <= '0;
      rdy    <= '0;
      tag    <= '0;
      data   <= '0;
    end else if (flush) begin
      valid  <= 1'b0;
    end else begin
      valid  <= n_valid;
      op     <= n_op;
      status <= n_status;
      rdy    <= n_rdy;
      tag    <= n_tag;
      data   <= n_data;
    end
  end

endmodule

// File: rtl/bru_issue_queue.sv
// Collapsing in-order-age issue queue for the branch unit; oldest operand-ready entry issues, dispatch-to-issue 1 cycle.
// Backpressure: disp_ready drops when full (registered count); entries wait while iss_ready is low.
module bru_issue_queue
  import bru_issue_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_WD = IQ_TAG_WD,
  parameter int ST_WD  = INST_STATE_WD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    disp_valid,
  output logic                    disp_ready,
  input  logic [BRU_OP_WD-1:0]    disp_op,
  input  logic [ST_WD-1:0]        disp_status,
  input  logic                    disp_src1_rdy,
  input  logic [TAG_WD-1:0]       disp_src1_tag,
  input  logic [31:0]             disp_src1_data,
  input  logic                    disp_src2_rdy,
  input  logic [TAG_WD-1:0]       disp_src2_tag,
  input  logic [31:0]             disp_src2_data,
  input  logic                    cdb_valid,
  input  logic [TAG_WD-1:0]       cdb_tag,
  input  logic [31:0]             cdb_data,
  output logic                    iss_valid,
  input  logic                    iss_ready,
  output logic [BRU_OP_WD-1:0]    iss_op,
  output logic [ST_WD-1:0]        iss_status,
  output logic [31:0]             iss_rdata1,
  output logic [31:0]             iss_rdata2,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  // Slot DEPTH is a permanently empty phantom so the youngest real slot shifts in nothing.
  logic                   e_valid  [DEPTH+1];
  logic [BRU_OP_WD-1:0]   e_op     [DEPTH+1];
  logic [ST_WD-1:0]       e_status [DEPTH+1];
  logic [1:0]             e_rdy    [DEPTH+1];
  logic [1:0][TAG_WD-1:0] e_tag    [DEPTH+1];
  logic [1:0][31:0]       e_data   [DEPTH+1];

  logic [DEPTH-1:0] e_elig;
  logic [IW-1:0]    sel;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    wr_idx;
  logic             disp_fire;
  logic             iss_fire;

  assign e_valid[DEPTH]  = 1'b0;
  assign e_op[DEPTH]     = '0;
  assign e_status[DEPTH] = '0;
  assign e_rdy[DEPTH]    = '0;
  assign e_tag[DEPTH]    = '0;
  assign e_data[DEPTH]   = '0;

  assign disp_ready = (cnt_q < CW'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign iss_valid  = |e_elig;
  assign iss_fire   = iss_valid && iss_ready && !flush;
  assign wr_idx     = cnt_q - CW'(iss_fire);
  assign count      = cnt_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign e_elig[i] = e_valid[i] && e_rdy[i][0] && e_rdy[i][1];

    bru_iq_entry #(
      .TAG_WD (TAG_WD),
      .ST_WD  (ST_WD)
    ) u_ent (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .load        (disp_fire && wr_idx == CW'(i)),
      .shift       (iss_fire && IW'(i) >= sel),
      .disp_op     (disp_op),
      .disp_status (disp_status),
      .disp_rdy    ({disp_src2_rdy, disp_src1_rdy}),
      .disp_tag    ({disp_src2_tag, disp_src1_tag}),
      .disp_data   ({disp_src2_data, disp_src1_data}),
      .up_valid    (e_valid[i+1]),
      .up_op       (e_op[i+1]),
      .up_status   (e_status[i+1]),
      .up_rdy      (e_rdy[i+1]),
      .up_tag      (e_tag[i+1]),
      .up_data     (e_data[i+1]),
      .cdb_valid   (cdb_valid),
      .cdb_tag     (cdb_tag),
      .cdb_data    (cdb_data),
      .valid       (e_valid[i]),
      .op          (e_op[i]),
      .status      (e_status[i]),
      .rdy         (e_rdy[i]),
      .tag         (e_tag[i]),
      .data        (e_data[i])
    );
  end

  always_comb begin
    sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (e_elig[i]) sel = IW'(i);
    end
  end

  always_comb begin
    iss_op     = '0;
    iss_status = '0;
    iss_rdata1 = '0;
    iss_rdata2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (iss_valid && sel == IW'(i)) begin
        iss_op     = e_op[i];
        iss_status = e_status[i];
        iss_rdata1 = e_data[i][0];
        iss_rdata2 = e_data[i][1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt_q <= '0;
    else if (flush) cnt_q <= '0;
    else            cnt_q <= cnt_q + CW'(disp_fire) - CW'(iss_fire);
  end

endmodule

// File: tb/tb_bru_issue_queue.sv
// Bench for bru_issue_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_bru_issue_queue;
  import bru_issue_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int TW    = IQ_TAG_WD;
  localparam int SW    = INST_STATE_WD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          disp_valid, disp_ready;
  logic [11:0]   disp_op;
  logic [SW-1:0] disp_status;
  logic          disp_src1_rdy, disp_src2_rdy;
  logic [TW-1:0] disp_src1_tag, disp_src2_tag;
  logic [31:0]   disp_src1_data, disp_src2_data;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [31:0]   cdb_data;
  logic          iss_valid, iss_ready;
  logic [11:0]   iss_op;
  logic [SW-1:0] iss_status;
  logic [31:0]   iss_rdata1, iss_rdata2;
  logic          flush;
  logic [2:0]    count;

  always #5 clk = ~clk;

  bru_issue_queue #(.DEPTH(DEPTH), .TAG_WD(TW), .ST_WD(SW)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_status(disp_status),
    .disp_src1_rdy(disp_src1_rdy), .disp_src1_tag(disp_src1_tag), .disp_src1_data(disp_src1_data),
    .disp_src2_rdy(disp_src2_rdy), .disp_src2_tag(disp_src2_tag), .disp_src2_data(disp_src2_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_status(iss_status),
    .iss_rdata1(iss_rdata1), .iss_rdata2(iss_rdata2),
    .flush(flush), .count(count)
  );

  typedef struct {
    logic [11:0]   op;
    logic [SW-1:0] st;
    bit            r1, r2;
    logic [TW-1:0] t1, t2;
    logic [31:0]   d1, d2;
  } ent_t;

  ent_t mq[$];
  int   total = 0;
  int   bad   = 0;
  int   op_bits[12] = '{OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
                        OP_BEQZ, OP_BNEZ, OP_BLEZ, OP_BGEZ, OP_JAL, OP_JALR};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t wk(input ent_t e);
    if (cdb_valid && !e.r1 && e.t1 == cdb_tag) begin e.r1 = 1'b1; e.d1 = cdb_data; end
    if (cdb_valid && !e.r2 && e.t2 == cdb_tag) begin e.r2 = 1'b1; e.d2 = cdb_data; end
    return e;
  endfunction

  task automatic idle();
    disp_valid = 0; disp_op = '0; disp_status = '0;
    disp_src1_rdy = 0; disp_src1_tag = '0; disp_src1_data = '0;
    disp_src2_rdy = 0; disp_src2_tag = '0; disp_src2_data = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_data = '0;
    iss_ready = 0; flush = 0;
  endtask

  task automatic put(input int opb, input bit r1, input int t1, input int d1,
                     input bit r2, input int t2, input int d2);
    disp_valid = 1'b1;
    disp_op = 12'd1 << opb;
    disp_status = '0;
    disp_status[PC_MSB:PC_LSB]   = $urandom;
    disp_status[IMM_MSB:IMM_LSB] = $urandom;
    disp_status[WE_BIT]          = 1'($urandom_range(1, 0));
    disp_src1_rdy = r1; disp_src1_tag = TW'(t1); disp_src1_data = 32'(d1);
    disp_src2_rdy = r2; disp_src2_tag = TW'(t2); disp_src2_data = 32'(d2);
  endtask

  // Check outputs against the model, advance the model across the coming edge, then step past it.
  task automatic step();
    int            s = -1;
    bit            dr;
    ent_t          ne;
    logic [11:0]   eop = '0;
    logic [SW-1:0] est = '0;
    logic [31:0]   ed1 = '0;
    logic [31:0]   ed2 = '0;
    #1;
    foreach (mq[k]) if (s < 0 && mq[k].r1 && mq[k].r2) s = k;
    if (s >= 0) begin
      eop = mq[s].op; est = mq[s].st; ed1 = mq[s].d1; ed2 = mq[s].d2;
    end
    dr = (mq.size() < DEPTH);
    chk("count", 128'(count), 128'(mq.size()));
    chk("disp_ready", 128'(disp_ready), 128'(dr));
    chk("iss_valid", 128'(iss_valid), 128'(s >= 0));
    chk("iss_op", 128'(iss_op), 128'(eop));
    chk("iss_status", 128'(iss_status), 128'(est));
    chk("iss_rdata1", 128'(iss_rdata1), 128'(ed1));
    chk("iss_rdata2", 128'(iss_rdata2), 128'(ed2));
    if (flush) mq.delete();
    else begin
      if (s >= 0 && iss_ready) mq.delete(s);
      for (int k = 0; k < mq.size(); k++) mq[k] = wk(mq[k]);
      if (disp_valid && dr) begin
        ne.op = disp_op; ne.st = disp_status;
        ne.r1 = disp_src1_rdy; ne.t1 = disp_src1_tag; ne.d1 = disp_src1_data;
        ne.r2 = disp_src2_rdy; ne.t2 = disp_src2_tag; ne.d2 = disp_src2_data;
        mq.push_back(wk(ne));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 128'(count), 0);
    chk("rst_disp_ready", 128'(disp_ready), 1);
    chk("rst_iss_valid", 128'(iss_valid), 0);
    chk("rst_iss_op", 128'(iss_op), 0);
    rst = 1'b0;

    // single beq, both operands ready
    idle(); put(OP_BEQ, 1, 0, 5, 1, 0, 5); iss_ready = 1; step();
    chk("beq_valid", 128'(iss_valid), 1);
    chk("beq_op", 128'(iss_op), 128'(12'd1 << OP_BEQ));
    chk("beq_rdata1", 128'(iss_rdata1), 5);
    idle(); iss_ready = 1; step();
    chk("beq_count", 128'(count), 0);

    // older pending entry is overtaken, then woken by the CDB
    idle(); put(OP_BNE, 0, 3, 0, 1, 0, 1); step();
    idle(); put(OP_BLT, 1, 0, 7, 1, 0, 8); step();
    chk("young_first", 128'(iss_op), 128'(12'd1 << OP_BLT));
    idle(); iss_ready = 1; cdb_valid = 1; cdb_tag = 3; cdb_data = 32'h40; step();
    chk("wake_valid", 128'(iss_valid), 1);
    chk("wake_rdata1", 128'(iss_rdata1), 128'h40);
    idle(); iss_ready = 1; step();

    // fill to DEPTH, overflow attempt ignored, one issue reopens dispatch
    for (int i = 0; i < DEPTH; i++) begin idle(); put(OP_JAL, 1, 0, i, 1, 0, i); step(); end
    chk("full_ready", 128'(disp_ready), 0);
    chk("full_count", 128'(count), 4);
    idle(); put(OP_JALR, 1, 0, 99, 1, 0, 99); step();
    idle(); iss_ready = 1; step();
    chk("drain_ready", 128'(disp_ready), 1);
    chk("drain_count", 128'(count), 3);
    idle(); flush = 1; step();

    // dispatch catches the same-cycle CDB broadcast
    idle(); put(OP_BGE, 1, 0, 1, 0, 7, 0); cdb_valid = 1; cdb_tag = 7; cdb_data = 32'h99; step();
    chk("bypass_valid", 128'(iss_valid), 1);
    chk("bypass_rdata2", 128'(iss_rdata2), 128'h99);
    idle(); iss_ready = 1; step();

    // flush beats simultaneous dispatch and issue
    for (int i = 0; i < 3; i++) begin idle(); put(OP_BLTU, 1, 0, i, 1, 0, i); step(); end
    idle(); put(OP_BGEU, 1, 0, 1, 1, 0, 2); iss_ready = 1; flush = 1; step();
    chk("flush_count", 128'(count), 0);
    chk("flush_valid", 128'(iss_valid), 0);
    idle(); step();

    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(1, 0) == 1)
        put(op_bits[$urandom_range(11, 0)], 1'($urandom_range(1, 0)), int'($urandom_range(7, 0)), int'($urandom),
            1'($urandom_range(1, 0)), int'($urandom_range(7, 0)), int'($urandom));
      cdb_valid = 1'($urandom_range(1, 0));
      cdb_tag   = TW'($urandom_range(7, 0));
      cdb_data  = $urandom;
      iss_ready = ($urandom_range(9, 0) < 7);
      flush     = ($urandom_range(99, 0) < 3);
      step();
    end

    // asynchronous reset with two waiting entries
    idle(); flush = 1; step();
    idle(); put(OP_BNEZ, 0, 1, 0, 1, 0, 0); step();
    idle(); put(OP_BGEZ, 0, 2, 0, 1, 0, 0); step();
    chk("pre_rst_count", 128'(count), 2);
    idle();
    #3 rst = 1'b1;
    #1;
    chk("arst_count", 128'(count), 0);
    chk("arst_disp_ready", 128'(disp_ready), 1);
    chk("arst_iss_valid", 128'(iss_valid), 0);
    chk("arst_iss_op", 128'(iss_op), 0);
    mq.delete();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    idle(); step();
    idle(); put(OP_BLEZ, 1, 0, 3, 1, 0, 4); step();
    idle(); iss_ready = 1; step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
